// File: rtl/mmio_sig_pkg.sv
// Shared types and MMIO signature-window addresses for the run-termination controller.
package mmio_sig_pkg;
    localparam int SIG_DATA_W = 64;

    localparam logic [31:0] ADDR_STOP       = 32'h6000_0000;
    localparam logic [31:0] ADDR_TRAP       = 32'h6000_0008;
    localparam logic [31:0] ADDR_REG_DUMP   = 32'h6000_0010;
    localparam logic [31:0] ADDR_FREG_DUMP  = 32'h6000_0018;
    localparam logic [31:0] ADDR_REG_STREAM = 32'h6000_0020;

    typedef enum logic [1:0] {
        KIND_INT    = 2'd0,
        KIND_FLOAT  = 2'd1,
        KIND_STREAM = 2'd2
    } rec_kind_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } sig_state_e;

    typedef struct packed {
        rec_kind_e               kind;
        logic [7:0]              idx;
        logic [SIG_DATA_W-1:0]   data;
        logic [SIG_DATA_W-1:0]   taint;
    } sig_rec_t;
endpackage

// File: rtl/sig_rec_fifo.sv
// Record FIFO with extra wrap bit on each pointer; head is read straight from storage.
module sig_rec_fifo
    import mmio_sig_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type rec_t = sig_rec_t
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  rec_t push_data_i,
    input  logic pop_i,
    output logic push_ok_o,
    output logic valid_o,
    output rec_t head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, rd_ptr_q;
    rec_t        mem_q [DEPTH];
    logic        empty, full, pop_ok;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok    = pop_i && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok_o = push_i && (!full || pop_ok);
    assign valid_o   = !empty;
    assign head_o    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push_ok_o) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop_ok) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/mmio_sig_ctrl.sv
// MMIO signature-window decoder, run-termination sequencer and dump-record queue.
//  state    | meaning
//  ST_RUN   | normal execution, dump beats recorded, stop/trap honoured
//  ST_DRAIN | countdown after stop/trap, beats ignored
//  ST_DONE  | terminal until reset, counters frozen, FIFO still drains
module mmio_sig_ctrl
    import mmio_sig_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = SIG_DATA_W,
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 50,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              mmio_req_i,
    input  logic              mmio_we_i,
    input  logic [ADDR_W-1:0] mmio_addr_i,
    input  logic [DATA_W-1:0] mmio_wdata_i,
    input  logic [DATA_W-1:0] mmio_wdata_t0_i,
    input  logic [CNT_W-1:0]  simlen_i,
    input  logic              trap_stop_en_i,
    output logic              rec_valid_o,
    input  logic              rec_ready_i,
    output logic [1:0]        rec_kind_o,
    output logic [7:0]        rec_idx_o,
    output logic [DATA_W-1:0] rec_data_o,
    output logic [DATA_W-1:0] rec_taint_o,
    output logic [1:0]        state_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  cycle_cnt_o,
    output logic [7:0]        trap_cnt_o,
    output logic              overflow_o
);
    localparam int CD_W = $clog2(DRAIN_CYCLES + 1);

    sig_state_e       state_q;
    logic [CD_W-1:0]  countdown_q;
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [7:0]       trap_cnt_q, idx_int_q, idx_flt_q, idx_str_q;
    logic             done_q, overflow_q;

    logic     wr_beat, hit_stop, hit_trap, hit_reg, hit_freg, hit_str, limit_hit;
    logic     push, push_ok;
    sig_rec_t push_rec, head;

    assign wr_beat  = mmio_req_i && mmio_we_i;
    assign hit_stop = wr_beat && (mmio_addr_i[31:0] == ADDR_STOP);
    assign hit_trap = mmio_req_i && (mmio_addr_i[31:0] == ADDR_TRAP);
    assign hit_reg  = wr_beat && (mmio_addr_i[31:0] == ADDR_REG_DUMP);
    assign hit_freg = wr_beat && (mmio_addr_i[31:0] == ADDR_FREG_DUMP);
    assign hit_str  = wr_beat && (mmio_addr_i[31:0] == ADDR_REG_STREAM);

    assign limit_hit = (simlen_i != '0) && (cycle_cnt_q == simlen_i - CNT_W'(1));
    assign push      = (state_q == ST_RUN) && (hit_reg || hit_freg || hit_str);

    always_comb begin
        push_rec       = '0;
        push_rec.data  = mmio_wdata_i;
        push_rec.taint = mmio_wdata_t0_i;
        if (hit_reg) begin
            push_rec.kind = KIND_INT;
            push_rec.idx  = idx_int_q;
        end else if (hit_freg) begin
            push_rec.kind  = KIND_FLOAT;
            push_rec.idx   = idx_flt_q;
            push_rec.taint = '0;
        end else begin
            push_rec.kind = KIND_STREAM;
            push_rec.idx  = idx_str_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_RUN;
            countdown_q <= '0;
            cycle_cnt_q <= '0;
            trap_cnt_q  <= '0;
            idx_int_q   <= 8'd1;
            idx_flt_q   <= '0;
            idx_str_q   <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (state_q != ST_DONE && cycle_cnt_q != '1) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            if (push && !push_ok) overflow_q <= 1'b1;
            unique case (state_q)
                ST_RUN: begin
                    if (hit_reg) idx_int_q <= idx_int_q + 8'd1;
                    if (hit_freg) idx_flt_q <= idx_flt_q + 8'd1;
                    if (hit_str) idx_str_q <= idx_str_q + 8'd1;
                    if (hit_trap && trap_cnt_q != 8'hFF) trap_cnt_q <= trap_cnt_q + 8'd1;
                    // The cycle limit takes priority over a stop/trap in the same cycle.
                    if (limit_hit) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else if (hit_stop || (hit_trap && trap_stop_en_i)) begin
                        state_q     <= ST_DRAIN;
                        countdown_q <= CD_W'(DRAIN_CYCLES);
                    end
                end
                ST_DRAIN: begin
                    if (limit_hit || countdown_q == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        countdown_q <= countdown_q - CD_W'(1);
                    end
                end
                default: state_q <= ST_DONE;
            endcase
        end
    end

    sig_rec_fifo #(.DEPTH(FIFO_DEPTH), .rec_t(sig_rec_t)) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push),
        .push_data_i (push_rec),
        .pop_i       (rec_ready_i),
        .push_ok_o   (push_ok),
        .valid_o     (rec_valid_o),
        .head_o      (head)
    );

    assign rec_kind_o  = head.kind;
    assign rec_idx_o   = head.idx;
    assign rec_data_o  = head.data;
    assign rec_taint_o = head.taint;
    assign state_o     = state_q;
    assign done_o      = done_q;
    assign cycle_cnt_o = cycle_cnt_q;
    assign trap_cnt_o  = trap_cnt_q;
    assign overflow_o  = overflow_q;
endmodule

// File: tb/tb_mmio_sig_ctrl.sv
// Scoreboard bench for mmio_sig_ctrl: expected records queued at drive time, compared on pop.
module tb_mmio_sig_ctrl;
    import mmio_sig_pkg::*;

    localparam int DEPTH = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        mmio_req_i = 1'b0, mmio_we_i = 1'b0;
    logic [31:0] mmio_addr_i = '0;
    logic [63:0] mmio_wdata_i = '0, mmio_wdata_t0_i = '0;
    logic [31:0] simlen_i = '0;
    logic        trap_stop_en_i = 1'b0;
    logic        rec_valid_o, rec_ready_i = 1'b1;
    logic [1:0]  rec_kind_o, state_o;
    logic [7:0]  rec_idx_o, trap_cnt_o;
    logic [63:0] rec_data_o, rec_taint_o;
    logic        done_o, overflow_o;
    logic [31:0] cycle_cnt_o;

    int       checks = 0, errors = 0;
    sig_rec_t sb[$];
    bit       run_m;
    bit       ovf_m;
    logic [7:0] idx_m [3];

    always #5 clk_i = ~clk_i;

    mmio_sig_ctrl #(.ADDR_W(32), .DATA_W(64), .CNT_W(32), .DRAIN_CYCLES(50), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .mmio_req_i(mmio_req_i), .mmio_we_i(mmio_we_i),
        .mmio_addr_i(mmio_addr_i), .mmio_wdata_i(mmio_wdata_i), .mmio_wdata_t0_i(mmio_wdata_t0_i),
        .simlen_i(simlen_i), .trap_stop_en_i(trap_stop_en_i), .rec_valid_o(rec_valid_o),
        .rec_ready_i(rec_ready_i), .rec_kind_o(rec_kind_o), .rec_idx_o(rec_idx_o),
        .rec_data_o(rec_data_o), .rec_taint_o(rec_taint_o), .state_o(state_o), .done_o(done_o),
        .cycle_cnt_o(cycle_cnt_o), .trap_cnt_o(trap_cnt_o), .overflow_o(overflow_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] simlen);
        rst_ni      = 1'b0;
        simlen_i    = simlen;
        mmio_req_i  = 1'b0;
        mmio_we_i   = 1'b0;
        sb.delete();
        run_m       = 1'b1;
        ovf_m       = 1'b0;
        idx_m[0]    = 8'd1;
        idx_m[1]    = 8'd0;
        idx_m[2]    = 8'd0;
        idle(2);
        rst_ni      = 1'b1;
    endtask

    // Drives one beat sampled at the next rising edge; returns 1 time unit after it.
    task automatic beat(input logic [31:0] addr, input logic we, input logic [63:0] d, input logic [63:0] t);
        int       k;
        sig_rec_t r;
        k = -1;
        if (we && run_m) begin
            if (addr == ADDR_REG_DUMP) k = 0;
            else if (addr == ADDR_FREG_DUMP) k = 1;
            else if (addr == ADDR_REG_STREAM) k = 2;
        end
        if (k >= 0) begin
            r.kind  = rec_kind_e'(k);
            r.idx   = idx_m[k];
            r.data  = d;
            r.taint = (k == 1) ? 64'd0 : t;
            if (sb.size() < DEPTH || (rec_ready_i && sb.size() > 0)) sb.push_back(r);
            else ovf_m = 1'b1;
            idx_m[k] = idx_m[k] + 8'd1;
        end
        mmio_req_i      = 1'b1;
        mmio_we_i       = we;
        mmio_addr_i     = addr;
        mmio_wdata_i    = d;
        mmio_wdata_t0_i = t;
        @(posedge clk_i);
        #1;
        mmio_req_i = 1'b0;
        mmio_we_i  = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && rec_valid_o && rec_ready_i) begin
            if (sb.size() == 0) begin
                chk("rec_unexpected", {63'd0, rec_valid_o}, 64'd0);
            end else begin
                sig_rec_t e;
                e = sb.pop_front();
                chk("rec_kind", {62'd0, rec_kind_o}, {62'd0, e.kind});
                chk("rec_idx", {56'd0, rec_idx_o}, {56'd0, e.idx});
                chk("rec_data", rec_data_o, e.data);
                chk("rec_taint", rec_taint_o, e.taint);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(32'd0);
        chk("rst_state", {62'd0, state_o}, 64'd0);
        chk("rst_done", {63'd0, done_o}, 64'd0);
        chk("rst_cycle", {32'd0, cycle_cnt_o}, 64'd0);
        chk("rst_trap", {56'd0, trap_cnt_o}, 64'd0);
        chk("rst_ovf", {63'd0, overflow_o}, 64'd0);
        chk("rst_valid", {63'd0, rec_valid_o}, 64'd0);
        chk("rst_data", rec_data_o, 64'd0);

        // Three int dumps plus one float dump whose taint must read back as zero.
        rec_ready_i = 1'b1;
        beat(ADDR_REG_DUMP, 1'b1, 64'hA, 64'h1);
        chk("t1_latency", {63'd0, rec_valid_o}, 64'd1);
        beat(ADDR_REG_DUMP, 1'b1, 64'hB, 64'h1);
        beat(ADDR_REG_DUMP, 1'b1, 64'hC, 64'h1);
        beat(ADDR_FREG_DUMP, 1'b1, 64'h55, 64'hFF);
        idle(3);
        chk("t1_drained", 64'(sb.size()), 64'd0);

        // Stop at cycle 20, dump ignored in DRAIN, DONE at 72.
        do_reset(32'd0);
        idle(20);
        chk("t2_cnt20", {32'd0, cycle_cnt_o}, 64'd20);
        beat(ADDR_STOP, 1'b1, 64'd0, 64'd0);
        chk("t2_drain", {62'd0, state_o}, 64'd1);
        chk("t2_cnt21", {32'd0, cycle_cnt_o}, 64'd21);
        run_m = 1'b0;
        beat(ADDR_REG_DUMP, 1'b1, 64'hDEAD, 64'h0);
        idle(49);
        chk("t2_still_drain", {62'd0, state_o}, 64'd1);
        chk("t2_cnt71", {32'd0, cycle_cnt_o}, 64'd71);
        idle(1);
        chk("t2_done", {62'd0, state_o}, 64'd2);
        chk("t2_done_o", {63'd0, done_o}, 64'd1);
        chk("t2_cnt72", {32'd0, cycle_cnt_o}, 64'd72);
        chk("t2_no_rec", {63'd0, rec_valid_o}, 64'd0);

        // Cycle limit alone, then limit coinciding with STOP.
        do_reset(32'd100);
        idle(99);
        chk("t3_run99", {62'd0, state_o}, 64'd0);
        chk("t3_cnt99", {32'd0, cycle_cnt_o}, 64'd99);
        idle(1);
        chk("t3_done", {62'd0, state_o}, 64'd2);
        chk("t3_cnt100", {32'd0, cycle_cnt_o}, 64'd100);
        idle(5);
        chk("t3_frozen", {32'd0, cycle_cnt_o}, 64'd100);
        do_reset(32'd30);
        idle(29);
        beat(ADDR_STOP, 1'b1, 64'd0, 64'd0);
        chk("t3_limit_wins", {62'd0, state_o}, 64'd2);
        chk("t3_cnt30", {32'd0, cycle_cnt_o}, 64'd30);

        // Trap counted only, then trap starting DRAIN.
        do_reset(32'd0);
        trap_stop_en_i = 1'b0;
        beat(ADDR_TRAP, 1'b0, 64'd0, 64'd0);
        chk("t4_trap1", {56'd0, trap_cnt_o}, 64'd1);
        chk("t4_run", {62'd0, state_o}, 64'd0);
        trap_stop_en_i = 1'b1;
        beat(ADDR_TRAP, 1'b1, 64'd0, 64'd0);
        chk("t4_trap2", {56'd0, trap_cnt_o}, 64'd2);
        chk("t4_drain", {62'd0, state_o}, 64'd1);
        trap_stop_en_i = 1'b0;

        // Overflow with a stalled consumer; index keeps advancing on drops.
        do_reset(32'd0);
        rec_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) beat(ADDR_REG_STREAM, 1'b1, 64'(100 + i), 64'(i));
        chk("t5_ovf", {63'd0, overflow_o}, {63'd0, ovf_m});
        chk("t5_queued", 64'(sb.size()), 64'd8);
        chk("t5_valid", {63'd0, rec_valid_o}, 64'd1);
        rec_ready_i = 1'b1;
        idle(10);
        chk("t5_drained", 64'(sb.size()), 64'd0);
        beat(ADDR_REG_STREAM, 1'b1, 64'h77, 64'h3);
        chk("t5_idx10_queued", {56'd0, sb[0].idx}, 64'd10);
        idle(2);

        // Full FIFO with simultaneous pop, then reset in DRAIN with records queued.
        do_reset(32'd0);
        rec_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) beat(ADDR_REG_DUMP, 1'b1, 64'(200 + i), 64'hF);
        chk("t6_full_no_ovf", {63'd0, overflow_o}, 64'd0);
        rec_ready_i = 1'b1;
        beat(ADDR_REG_DUMP, 1'b1, 64'h1234, 64'h5);
        chk("t6_pushpop_no_ovf", {63'd0, overflow_o}, {63'd0, ovf_m});
        idle(12);
        chk("t6_drained", 64'(sb.size()), 64'd0);
        rec_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) beat(ADDR_REG_STREAM, 1'b1, 64'(300 + i), 64'h0);
        beat(ADDR_STOP, 1'b1, 64'd0, 64'd0);
        chk("t6_drain", {62'd0, state_o}, 64'd1);
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_state", {62'd0, state_o}, 64'd0);
        chk("t6_rst_valid", {63'd0, rec_valid_o}, 64'd0);
        chk("t6_rst_cycle", {32'd0, cycle_cnt_o}, 64'd0);
        do_reset(32'd0);
        rec_ready_i = 1'b1;
        idle(2);
        chk("t6_empty_after", {63'd0, rec_valid_o}, 64'd0);

        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
